// File: rtl/descrack_stream_sink.sv
// rtl/descrack_stream_sink.sv - end of the descrack FSL chain: frame parser, frame FIFO, host stream
//
// Purpose: parses the result stream coming from the last descrack_stream_core. Each valid frame is
// stored whole in a FIFO and shown to the host only after its last word has arrived. The FSL side
// cannot be stalled, so the parser reserves space when it accepts a header. A frame that does not
// fit is dropped whole. Headers with a bad tag or a zero length are rejected and counted.
//
// Ports:
//   clk           in   1   single clock for the FSL input, the FIFO and the host output
//   rst           in   1   synchronous, active-high; clears pointers, FSM, output stage and counters
//   fsl_rst_i     in   1   chain reset; drops the partial frame and keeps committed frames
//   fsl_data_i    in   32  chain data word
//   fsl_valid_i   in   1   word valid, one word per cycle, never stalled
//   out_data      out  32  host stream data (registered first-word-fall-through stage)
//   out_valid     out  1   host stream valid
//   out_last      out  1   high on the final payload word of a frame
//   out_ready     in   1   host takes the word when out_valid and out_ready are both high
//   frame_count   out  16  committed frames, saturating
//   drop_count    out  16  frames dropped for lack of space or an oversize length, saturating
//   bad_hdr_count out  16  rejected header words, saturating
module descrack_stream_sink #(
  parameter int          DEPTH = 512,
  parameter int          AW    = 9,
  parameter logic [7:0]  MAGIC = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fsl_rst_i,
  input  logic [31:0] fsl_data_i,
  input  logic        fsl_valid_i,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count,
  output logic [15:0] bad_hdr_count
);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP} state_t;

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_rem, w_rem_nxt;
  logic [AW:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [32:0] r_mem [DEPTH];

  logic        w_wr_en, w_wr_last, w_commit;
  logic        w_inc_frame, w_inc_drop, w_inc_bad;
  logic [15:0] w_hdr_len;
  logic [7:0]  w_hdr_magic;
  logic [AW:0] w_used;
  logic [16:0] w_free, w_need;
  logic        w_no_room, w_avail, w_load;

  assign w_hdr_magic = fsl_data_i[31:24];
  assign w_hdr_len   = fsl_data_i[15:0];

  // Occupancy uses the registered read pointer, so a word leaving this cycle gives no credit.
  // The header needs room for itself plus len payload words.
  assign w_used    = r_wr_ptr - r_rd_ptr;
  assign w_free    = 17'(DEPTH) - {{(16-AW){1'b0}}, w_used};
  assign w_need    = {1'b0, w_hdr_len} + 17'd1;
  assign w_no_room = (w_hdr_len > 16'(DEPTH-1)) || (w_free < w_need);

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_wr_en     = 1'b0;
    w_wr_last   = 1'b0;
    w_commit    = 1'b0;
    w_inc_frame = 1'b0;
    w_inc_drop  = 1'b0;
    w_inc_bad   = 1'b0;
    if (fsl_rst_i) begin
      w_state_nxt = S_IDLE;
    end else if (fsl_valid_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_hdr_magic != MAGIC || w_hdr_len == 16'd0) begin
            w_inc_bad = 1'b1;
          end else if (w_no_room) begin
            w_inc_drop  = 1'b1;
            w_rem_nxt   = w_hdr_len;
            w_state_nxt = S_DROP;
          end else begin
            w_wr_en     = 1'b1;
            w_rem_nxt   = w_hdr_len;
            w_state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          w_wr_en   = 1'b1;
          w_rem_nxt = r_rem - 16'd1;
          if (r_rem == 16'd1) begin
            w_wr_last   = 1'b1;
            w_commit    = 1'b1;
            w_inc_frame = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_DROP: begin
          w_rem_nxt = r_rem - 16'd1;
          if (r_rem == 16'd1) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rem        <= 16'd0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (fsl_rst_i)     r_wr_ptr <= r_commit_ptr;
      else if (w_wr_en)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_commit)      r_commit_ptr <= r_wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {w_wr_last, fsl_data_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count   <= 16'd0;
      drop_count    <= 16'd0;
      bad_hdr_count <= 16'd0;
    end else begin
      if (w_inc_frame && frame_count   != 16'hFFFF) frame_count   <= frame_count + 16'd1;
      if (w_inc_drop  && drop_count    != 16'hFFFF) drop_count    <= drop_count + 16'd1;
      if (w_inc_bad   && bad_hdr_count != 16'hFFFF) bad_hdr_count <= bad_hdr_count + 16'd1;
    end
  end

  // The read side only sees committed words. The output register refills whenever it is empty
  // or its word is being taken, which gives one word per cycle under continuous ready.
  assign w_avail = (r_rd_ptr != r_commit_ptr);
  assign w_load  = w_avail && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 32'd0;
    end else if (w_load) begin
      {out_last, out_data} <= r_mem[r_rd_ptr[AW-1:0]];
      out_valid            <= 1'b1;
      r_rd_ptr             <= r_rd_ptr + PTR_ONE;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
